// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: state encoding, field widths,
// the per-stage control bundle and the load-use compare.
package pipeline_ctrl_pkg;

  localparam logic RUN     = 1'b0;
  localparam logic MD_BUSY = 1'b1;

  typedef enum logic {
    ST_RUN     = RUN,
    ST_MD_BUSY = MD_BUSY
  } md_state_e;

  localparam int REG_IDX_W = 5;
  localparam int MD_CNT_W  = 8;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_bubble;
  } hazard_ctrl_t;

  // x0 is never a real producer, so a load targeting it cannot create a hazard.
  function automatic logic load_use_hit(
    input logic                 mem_read,
    input logic [REG_IDX_W-1:0] rd,
    input logic [REG_IDX_W-1:0] rs1,
    input logic [REG_IDX_W-1:0] rs2,
    input logic                 use_rs1,
    input logic                 use_rs2
  );
    return mem_read && (rd != '0) &&
           ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard inputs from the pipeline and the stall/flush/bubble controls returned to it.
interface pipeline_hazard_controller_if
  import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
);

    logic                 BRANCH_SELECT;
    logic [REG_IDX_W-1:0] ID_RS1;
    logic [REG_IDX_W-1:0] ID_RS2;
    logic                 ID_USE_RS1;
    logic                 ID_USE_RS2;
    logic                 EX_MEM_READ;
    logic [REG_IDX_W-1:0] EX_RD;
    logic                 EX_MULDIV;
    logic                 DMEM_BUSY;

    logic                 PC_STALL;
    logic                 IF_ID_STALL;
    logic                 ID_EX_STALL;
    logic                 EX_MEM_STALL;
    logic                 IF_ID_FLUSH;
    logic                 ID_EX_FLUSH;
    logic                 EX_MEM_BUBBLE;
    logic [CNT_WIDTH-1:0] STALL_COUNT;
    logic [CNT_WIDTH-1:0] FLUSH_COUNT;

    // Pipeline side: reports hazards, consumes controls.
    modport master (
        output BRANCH_SELECT, ID_RS1, ID_RS2, ID_USE_RS1, ID_USE_RS2,
               EX_MEM_READ, EX_RD, EX_MULDIV, DMEM_BUSY,
        input  PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL,
               IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_BUBBLE, STALL_COUNT, FLUSH_COUNT
    );

    // Controller side.
    modport slave (
        input  BRANCH_SELECT, ID_RS1, ID_RS2, ID_USE_RS1, ID_USE_RS2,
               EX_MEM_READ, EX_RD, EX_MULDIV, DMEM_BUSY,
        output PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL,
               IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_BUBBLE, STALL_COUNT, FLUSH_COUNT
    );

endinterface

// File: rtl/pipeline_hazard_controller_event_counter.sv
// Saturating event counter: counts qualifying cycles and sticks at all-ones.
module hazard_event_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait, MUL/DIV occupancy,
// taken branch and load-use, resolved by fixed priority in that order.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                       CLK,
    input  logic                       RESET,
    pipeline_hazard_controller_if.slave hz,
    output md_state_e                  dbg_state,
    output logic [MD_CNT_W-1:0]        dbg_md_cnt
);

    // Entry cycle plus the decrementing cycles give MD_LATENCY-1 stalls; the cycle at
    // md_cnt==0 lets the instruction advance. MD_LATENCY must lie in 2..255.
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 2);
    localparam logic [MD_CNT_W-1:0] MD_ONE  = MD_CNT_W'(1);

    md_state_e            state_q, state_d;
    logic [MD_CNT_W-1:0]  md_cnt_q, md_cnt_d;
    hazard_ctrl_t         ctrl;
    logic                 md_active;
    logic                 load_use;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q  <= ST_RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    always_comb begin
        ctrl      = '0;
        state_d   = state_q;
        md_cnt_d  = md_cnt_q;
        md_active = ((state_q == ST_RUN) && hz.EX_MULDIV) ||
                    ((state_q == ST_MD_BUSY) && (md_cnt_q != '0));
        load_use  = load_use_hit(hz.EX_MEM_READ, hz.EX_RD, hz.ID_RS1, hz.ID_RS2,
                                 hz.ID_USE_RS1, hz.ID_USE_RS2);

        if (!RESET) begin
            ctrl = '0;
        end else if (hz.DMEM_BUSY) begin
            // Whole front of the pipe freezes; MUL/DIV progress freezes with it.
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_stall  = 1'b1;
            ctrl.ex_mem_stall = 1'b1;
        end else if (md_active) begin
            ctrl.pc_stall      = 1'b1;
            ctrl.if_id_stall   = 1'b1;
            ctrl.id_ex_stall   = 1'b1;
            ctrl.ex_mem_bubble = 1'b1;
            if (state_q == ST_RUN) begin
                state_d  = ST_MD_BUSY;
                md_cnt_d = MD_LOAD;
            end else begin
                md_cnt_d = md_cnt_q - MD_ONE;
            end
        end else begin
            // Release cycle: EX_MULDIV is still high here but must not retrigger.
            if (state_q == ST_MD_BUSY) begin
                state_d = ST_RUN;
            end
            if (hz.BRANCH_SELECT) begin
                ctrl.if_id_flush = 1'b1;
                ctrl.id_ex_flush = 1'b1;
            end else if (load_use) begin
                ctrl.pc_stall    = 1'b1;
                ctrl.if_id_stall = 1'b1;
                ctrl.id_ex_flush = 1'b1;
            end
        end
    end

    assign hz.PC_STALL      = ctrl.pc_stall;
    assign hz.IF_ID_STALL   = ctrl.if_id_stall;
    assign hz.ID_EX_STALL   = ctrl.id_ex_stall;
    assign hz.EX_MEM_STALL  = ctrl.ex_mem_stall;
    assign hz.IF_ID_FLUSH   = ctrl.if_id_flush;
    assign hz.ID_EX_FLUSH   = ctrl.id_ex_flush;
    assign hz.EX_MEM_BUBBLE = ctrl.ex_mem_bubble;

    assign dbg_state  = state_q;
    assign dbg_md_cnt = md_cnt_q;

    hazard_event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (CLK),
        .rst_n (RESET),
        .inc   (ctrl.pc_stall),
        .count (hz.STALL_COUNT)
    );

    hazard_event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (CLK),
        .rst_n (RESET),
        .inc   (ctrl.if_id_flush),
        .count (hz.FLUSH_COUNT)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two instances (latency 4 / 32-bit counters and
// latency 2 / 4-bit counters) driven identically and compared with an occupancy model.
module tb_pipeline_hazard_controller;
  import pipeline_ctrl_pkg::*;

  localparam int LAT_A = 4;
  localparam int CW_A  = 32;
  localparam int LAT_B = 2;
  localparam int CW_B  = 4;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  pipeline_hazard_controller_if #(.CNT_WIDTH(CW_A)) hz_a ();
  pipeline_hazard_controller_if #(.CNT_WIDTH(CW_B)) hz_b ();

  md_state_e               dbg_state_a, dbg_state_b;
  logic [MD_CNT_W-1:0]     dbg_md_cnt_a, dbg_md_cnt_b;

  pipeline_hazard_controller #(.MD_LATENCY(LAT_A), .CNT_WIDTH(CW_A)) dut_a (
    .CLK        (CLK),
    .RESET      (RESET),
    .hz         (hz_a),
    .dbg_state  (dbg_state_a),
    .dbg_md_cnt (dbg_md_cnt_a)
  );

  pipeline_hazard_controller #(.MD_LATENCY(LAT_B), .CNT_WIDTH(CW_B)) dut_b (
    .CLK        (CLK),
    .RESET      (RESET),
    .hz         (hz_b),
    .dbg_state  (dbg_state_b),
    .dbg_md_cnt (dbg_md_cnt_b)
  );

  // ---------------- stimulus state ----------------
  logic       s_rst, s_br, s_u1, s_u2, s_mr, s_md, s_dm;
  logic [4:0] s_rs1, s_rs2, s_rd;

  // ---------------- reference model ----------------
  // occ = EX occupancy cycles still to run for the current MUL/DIV (0 = none);
  // every occupancy cycle except the last one is stalled.
  int          occ_a, occ_b;
  longint      stall_a, flush_a, stall_b, flush_b;
  logic [63:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [6:0] exp_ctrl(input int occ);
    logic lu;
    lu = s_mr && (s_rd != 5'd0) &&
         ((s_u1 && (s_rs1 == s_rd)) || (s_u2 && (s_rs2 == s_rd)));
    if (!s_rst)                     return 7'b0000000;
    if (s_dm)                       return 7'b1111000;
    if ((occ == 0 && s_md) || occ > 1) return 7'b1110001;
    if (s_br)                       return 7'b0000110;
    if (lu)                         return 7'b1100010;
    return 7'b0000000;
  endfunction

  function automatic int next_occ(input int occ, input int lat);
    if (!s_rst) return 0;
    if (s_dm)   return occ;
    if (occ == 0) return s_md ? lat - 1 : 0;
    return occ - 1;
  endfunction

  function automatic longint sat_inc(input longint v, input logic inc, input longint max);
    if (!s_rst) return 0;
    if (inc && v < max) return v + 1;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic set_idle();
    s_rst = 1'b1; s_br = 1'b0; s_u1 = 1'b0; s_u2 = 1'b0; s_mr = 1'b0;
    s_md = 1'b0; s_dm = 1'b0; s_rs1 = '0; s_rs2 = '0; s_rd = '0;
  endtask

  task automatic apply_inputs();
    RESET = s_rst;
    hz_a.BRANCH_SELECT = s_br;  hz_b.BRANCH_SELECT = s_br;
    hz_a.ID_RS1 = s_rs1;        hz_b.ID_RS1 = s_rs1;
    hz_a.ID_RS2 = s_rs2;        hz_b.ID_RS2 = s_rs2;
    hz_a.ID_USE_RS1 = s_u1;     hz_b.ID_USE_RS1 = s_u1;
    hz_a.ID_USE_RS2 = s_u2;     hz_b.ID_USE_RS2 = s_u2;
    hz_a.EX_MEM_READ = s_mr;    hz_b.EX_MEM_READ = s_mr;
    hz_a.EX_RD = s_rd;          hz_b.EX_RD = s_rd;
    hz_a.EX_MULDIV = s_md;      hz_b.EX_MULDIV = s_md;
    hz_a.DMEM_BUSY = s_dm;      hz_b.DMEM_BUSY = s_dm;
  endtask

  // One cycle: drive at negedge, check combinational controls and registered
  // state/counters mid-cycle, then advance the model across the coming posedge.
  task automatic cycle();
    logic [6:0]  ea, eb, ga, gb;
    logic [63:0] exp_cnt;
    @(negedge CLK);
    apply_inputs();
    #1;
    ea = exp_ctrl(occ_a);
    eb = exp_ctrl(occ_b);
    ga = {hz_a.PC_STALL, hz_a.IF_ID_STALL, hz_a.ID_EX_STALL, hz_a.EX_MEM_STALL,
          hz_a.IF_ID_FLUSH, hz_a.ID_EX_FLUSH, hz_a.EX_MEM_BUBBLE};
    gb = {hz_b.PC_STALL, hz_b.IF_ID_STALL, hz_b.ID_EX_STALL, hz_b.EX_MEM_STALL,
          hz_b.IF_ID_FLUSH, hz_b.ID_EX_FLUSH, hz_b.EX_MEM_BUBBLE};
    check_eq("ctrl_a", 64'(ga), 64'(ea));
    check_eq("ctrl_b", 64'(gb), 64'(eb));
    check_eq("busy_a", 64'(dbg_state_a == ST_MD_BUSY), 64'(occ_a > 0));
    check_eq("busy_b", 64'(dbg_state_b == ST_MD_BUSY), 64'(occ_b > 0));
    check_eq("md_cnt_a", 64'(dbg_md_cnt_a), 64'((occ_a > 0) ? occ_a - 1 : 0));
    if (exp_q.size() >= 2) begin
      exp_cnt = exp_q.pop_front();
      check_eq("cnt_a", {hz_a.STALL_COUNT, hz_a.FLUSH_COUNT}, exp_cnt);
      exp_cnt = exp_q.pop_front();
      check_eq("cnt_b", {28'd0, hz_b.STALL_COUNT, 28'd0, hz_b.FLUSH_COUNT}, exp_cnt);
    end
    stall_a = sat_inc(stall_a, ea[6], 64'hFFFF_FFFF);
    flush_a = sat_inc(flush_a, ea[2], 64'hFFFF_FFFF);
    stall_b = sat_inc(stall_b, eb[6], 15);
    flush_b = sat_inc(flush_b, eb[2], 15);
    occ_a   = next_occ(occ_a, LAT_A);
    occ_b   = next_occ(occ_b, LAT_B);
    exp_q.push_back({stall_a[31:0], flush_a[31:0]});
    exp_q.push_back({stall_b[31:0], flush_b[31:0]});
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- test sequence ----------------
  longint base;

  initial begin
    set_idle();
    s_rst = 1'b0;
    apply_inputs();
    @(posedge CLK);
    occ_a = 0; occ_b = 0;
    stall_a = 0; flush_a = 0; stall_b = 0; flush_b = 0;
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd0);

    // Reset held with competing hazards: everything stays quiet.
    s_rst = 1'b0; s_br = 1'b1; s_md = 1'b1;
    cycles(2);
    set_idle(); s_br = 1'b1;
    cycle();
    set_idle();
    cycle();
    check_eq("flush_after_reset", 64'(hz_a.FLUSH_COUNT), 64'd1);

    // Load-use on rs2, then the same with rd = x0.
    base = longint'(hz_a.STALL_COUNT);
    s_mr = 1'b1; s_rd = 5'd5; s_rs2 = 5'd5; s_u2 = 1'b1;
    cycle();
    set_idle();
    cycle();
    check_eq("load_use_stall", 64'(longint'(hz_a.STALL_COUNT) - base), 64'd1);
    s_mr = 1'b1; s_rd = 5'd0; s_rs2 = 5'd0; s_u2 = 1'b1;
    cycle();
    set_idle();
    cycle();
    check_eq("x0_no_stall", 64'(longint'(hz_a.STALL_COUNT) - base), 64'd1);

    // MUL/DIV held for its full latency.
    base = longint'(hz_a.STALL_COUNT);
    s_md = 1'b1;
    cycles(LAT_A);
    set_idle();
    cycle();
    check_eq("md_state_run", 64'(dbg_state_a), 64'(ST_RUN));
    check_eq("md_stalls", 64'(longint'(hz_a.STALL_COUNT) - base), 64'd3);

    // Memory wait while md_cnt is 1.
    base = longint'(hz_a.STALL_COUNT);
    s_md = 1'b1;
    cycles(2);
    s_dm = 1'b1;
    cycles(2);
    check_eq("md_cnt_hold", 64'(dbg_md_cnt_a), 64'd1);
    s_dm = 1'b0;
    cycles(2);
    set_idle();
    cycle();
    check_eq("md_dmem_stalls", 64'(longint'(hz_a.STALL_COUNT) - base), 64'd5);

    // Branch and load-use together, then with a memory wait on top.
    s_br = 1'b1; s_mr = 1'b1; s_rd = 5'd7; s_rs1 = 5'd7; s_u1 = 1'b1;
    cycle();
    s_dm = 1'b1;
    cycle();
    set_idle();
    cycle();

    // Counter saturation on the 4-bit instance.
    s_dm = 1'b1;
    cycles(20);
    set_idle();
    cycle();
    check_eq("stall_saturate", 64'(hz_b.STALL_COUNT), 64'd15);

    // Reset in the middle of a MUL/DIV abandons it.
    s_md = 1'b1;
    cycles(2);
    s_rst = 1'b0;
    cycle();
    set_idle();
    cycle();
    check_eq("mid_op_reset_state", 64'(dbg_state_a), 64'(ST_RUN));
    cycle();

    // Randomized traffic; no branch or load while either instance holds a MUL/DIV in EX.
    for (int i = 0; i < 400; i++) begin
      s_rst = ($urandom_range(0, 49) != 0);
      s_dm  = ($urandom_range(0, 4) == 0);
      s_md  = ($urandom_range(0, 7) == 0);
      s_rs1 = 5'($urandom_range(0, 3));
      s_rs2 = 5'($urandom_range(0, 3));
      s_rd  = 5'($urandom_range(0, 3));
      s_u1  = 1'($urandom_range(0, 1));
      s_u2  = 1'($urandom_range(0, 1));
      if (occ_a != 0 || occ_b != 0) begin
        s_br = 1'b0;
        s_mr = 1'b0;
      end else begin
        s_br = ($urandom_range(0, 5) == 0);
        s_mr = ($urandom_range(0, 2) == 0);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage RV32IM pipeline (IF, ID, EX, MEM, WB).
- Combines four hazard sources into per-stage stall, flush and bubble controls:
  - taken branch/jump resolved in EX (BRANCH_SELECT from the branch control unit)
  - load-use hazard at ID
  - multi-cycle M-extension operation in EX
  - data-memory wait
- Holds the MUL/DIV occupancy FSM and counter, plus saturating stall and flush event counters for performance analysis.

Parameters:
- MD_LATENCY, 4: cycles an M-extension instruction occupies EX; legal range 2..255.
- CNT_WIDTH, 32: width of STALL_COUNT and FLUSH_COUNT.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-low reset.
- BRANCH_SELECT  in  1  taken branch or jump resolved in EX this cycle.
- ID_RS1  in  5  rs1 of the instruction in ID.
- ID_RS2  in  5  rs2 of the instruction in ID.
- ID_USE_RS1  in  1  ID instruction reads rs1.
- ID_USE_RS2  in  1  ID instruction reads rs2.
- EX_MEM_READ  in  1  EX instruction is a load.
- EX_RD  in  5  destination register of the EX instruction.
- EX_MULDIV  in  1  EX holds a valid MUL/DIV/REM instruction.
- DMEM_BUSY  in  1  data memory has not completed the MEM-stage access.
- PC_STALL  out  1  hold PC.
- IF_ID_STALL  out  1  hold IF/ID register.
- ID_EX_STALL  out  1  hold ID/EX register.
- EX_MEM_STALL  out  1  hold EX/MEM register.
- IF_ID_FLUSH  out  1  load NOP into IF/ID.
- ID_EX_FLUSH  out  1  load NOP into ID/EX.
- EX_MEM_BUBBLE  out  1  load NOP into EX/MEM.
- STALL_COUNT  out  CNT_WIDTH  cycles with PC_STALL=1; registered.
- FLUSH_COUNT  out  CNT_WIDTH  cycles with IF_ID_FLUSH=1; registered.

Behaviour:
- State registers: state in {RUN, MD_BUSY}, 8-bit md_cnt, two counters.
- Control outputs are combinational from state, md_cnt and inputs, taking effect in the same cycle. Counters are registered.
- While RESET=0: all control outputs forced 0. At the clock edge: state<=RUN, md_cnt<=0, STALL_COUNT<=0, FLUSH_COUNT<=0.
- Priority, highest first; only the winning rule drives outputs, all others read 0:
  - P1, DMEM_BUSY=1: PC_STALL, IF_ID_STALL, ID_EX_STALL and EX_MEM_STALL all 1. No flush or bubble. State and md_cnt hold.
  - P2, MD occupancy:
    - Active when (state=RUN and EX_MULDIV=1) or (state=MD_BUSY and md_cnt!=0).
    - Outputs: PC_STALL, IF_ID_STALL, ID_EX_STALL and EX_MEM_BUBBLE all 1.
    - Transition RUN->MD_BUSY loads md_cnt=MD_LATENCY-2.
    - In MD_BUSY with md_cnt!=0: md_cnt decrements.
    - In MD_BUSY with md_cnt=0: no stall this cycle (the instruction advances), next state RUN, EX_MULDIV ignored. This prevents retrigger.
    - Net effect: EX occupancy is exactly MD_LATENCY cycles, of which MD_LATENCY-1 are stalled.
  - P3, BRANCH_SELECT=1 (state RUN): IF_ID_FLUSH=1, ID_EX_FLUSH=1. Any load-use condition is suppressed because the ID instruction is discarded.
  - P4, load-use:
    - Condition: EX_MEM_READ and EX_RD!=0 and ((ID_USE_RS1 and ID_RS1==EX_RD) or (ID_USE_RS2 and ID_RS2==EX_RD)).
    - Outputs: PC_STALL=1, IF_ID_STALL=1, ID_EX_FLUSH=1.
- EX_MULDIV and BRANCH_SELECT together are illegal upstream; if both occur, P2 wins.
- With MD_LATENCY=2, MD_BUSY is entered with md_cnt=0 and lasts one unstalled cycle.
- Counters: each increments by 1 per qualifying cycle with RESET=1, saturates at all-ones and does not wrap.
- A reset mid MD_BUSY abandons the operation; the MUL/DIV unit is reset by the same signal.

Decomposition:
- Shared package pipeline_ctrl_pkg:
  - state encoding localparams RUN=1'b0, MD_BUSY=1'b1
  - register-index width 5
  - MD counter width 8
  - the NOP instruction constant 32'h00000013 used by the stage registers
- Sub-module hazard_event_counter: saturating counter with CNT_WIDTH, inc, synchronous active-low reset. Instantiated twice.

Test Plan:
- Reset: RESET=0 for 2 cycles with BRANCH_SELECT=1 and EX_MULDIV=1 -> all controls 0 throughout, counters 0. After release, BRANCH_SELECT=1 -> IF_ID_FLUSH=ID_EX_FLUSH=1, FLUSH_COUNT=1 next cycle.
- Load-use, rs2 match:
  - EX_MEM_READ=1, EX_RD=5, ID_RS2=5, ID_USE_RS2=1 for one cycle -> PC_STALL=IF_ID_STALL=ID_EX_FLUSH=1 for that cycle, STALL_COUNT=1.
  - Repeat with EX_RD=0 -> no stall.
- MUL/DIV occupancy, MD_LATENCY=4: EX_MULDIV held 1 -> stalls and EX_MEM_BUBBLE in cycles 0-2, none in cycle 3, state RUN at cycle 4, STALL_COUNT=3.
- Memory wait inside MUL/DIV: in the same sequence assert DMEM_BUSY for 2 cycles when md_cnt=1 -> all four *_STALL=1 and no bubble; md_cnt holds at 1; total STALL_COUNT=5.
- Branch and load-use in the same cycle -> only IF_ID_FLUSH and ID_EX_FLUSH are 1, FLUSH_COUNT+1, STALL_COUNT unchanged. Same inputs with DMEM_BUSY=1 -> stall pattern only, no flush.
- Saturation and mid-op reset:
  - CNT_WIDTH=4, PC_STALL forced for 20 cycles -> STALL_COUNT stops at 15.
  - RESET=0 during MD_BUSY (md_cnt=1), then EX_MULDIV=0 -> state RUN and no stalls.
